// File: rtl/hdmi_timing_ctrl.sv
// HDMI raster timing generator with lock-settle start-up sequencing and a
// frame-driven test-pattern selector; everything runs on pixclk.
module hdmi_timing_ctrl #(
    parameter int       H_ACTIVE           = 640,
    parameter int       H_FP               = 16,
    parameter int       H_SYNC             = 96,
    parameter int       H_BP               = 48,
    parameter int       V_ACTIVE           = 480,
    parameter int       V_FP               = 10,
    parameter int       V_SYNC             = 2,
    parameter int       V_BP               = 33,
    parameter logic     SYNC_ACT           = 1'b0,
    parameter int       LOCK_WAIT          = 1024,
    parameter int       FRAMES_PER_PATTERN = 120,
    parameter int       NUM_PATTERNS       = 4
) (
    input  logic       pixclk,
    input  logic       rst_n,
    input  logic       clk_locked,
    input  logic       pattern_hold,
    output logic       video_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [1:0] pattern_sel
);

    // state      | meaning
    // WAIT_LOCK  | blanked, waiting for synchronized lock
    // SETTLE     | lock seen, counting consecutive locked cycles
    // RUN        | raster running, video enabled
    typedef enum logic [1:0] {ST_WAIT_LOCK, ST_SETTLE, ST_RUN} state_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCW     = $clog2(LOCK_WAIT + 1);
    localparam int FCW     = $clog2(FRAMES_PER_PATTERN + 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0]     sync_q;
    logic           lock_s;
    state_t         state_q, state_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [FCW-1:0] frame_q, frame_d;
    logic [1:0]     pat_q, pat_d;
    logic [9:0]     h_q, h_d, v_q, v_d;
    logic           de_q, hs_q, vs_q, fs_q;
    logic           run_q, run_d, h_wrap, v_wrap, eof;

    assign lock_s = sync_q[1];
    assign run_q  = (state_q == ST_RUN);
    assign run_d  = (state_d == ST_RUN);
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign eof    = run_q && run_d && h_wrap && v_wrap;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = ST_SETTLE;
                    settle_d = SCW'(1);
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q >= SCW'(LOCK_WAIT - 1)) begin
                    state_d  = ST_RUN;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_WAIT_LOCK;
            end
            default: begin
                state_d  = ST_WAIT_LOCK;
                settle_d = '0;
            end
        endcase
    end

    // Raster restarts at 0/0 on RUN entry; any exit abandons the frame.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run_q && run_d) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            v_d = h_wrap ? (v_wrap ? 10'd0 : v_q + 10'd1) : v_q;
        end
    end

    always_comb begin
        frame_d = frame_q;
        pat_d   = pat_q;
        if (!run_d) begin
            frame_d = '0;
        end else if (eof && !pattern_hold) begin
            if (frame_q == FCW'(FRAMES_PER_PATTERN - 1)) begin
                frame_d = '0;
                pat_d   = (pat_q == 2'(NUM_PATTERNS - 1)) ? 2'd0 : pat_q + 2'd1;
            end else begin
                frame_d = frame_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= ST_WAIT_LOCK;
            settle_q <= '0;
            frame_q  <= '0;
            pat_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            de_q     <= 1'b0;
            hs_q     <= ~SYNC_ACT;
            vs_q     <= ~SYNC_ACT;
            fs_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], clk_locked};
            state_q  <= state_d;
            settle_q <= settle_d;
            frame_q  <= frame_d;
            pat_q    <= pat_d;
            h_q      <= h_d;
            v_q      <= v_d;
            // Decoded from the next counter values so they line up with hcount/vcount.
            de_q     <= run_d && (h_d < H_ACT) && (v_d < V_ACT);
            hs_q     <= (run_d && (h_d >= HS_BEG) && (h_d < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            vs_q     <= (run_d && (v_d >= VS_BEG) && (v_d < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
            fs_q     <= run_d && (h_d == 10'd0) && (v_d == 10'd0);
        end
    end

    assign video_en    = run_q;
    assign hcount      = h_q;
    assign vcount      = v_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
    assign pattern_sel = pat_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Scoreboarded bench for hdmi_timing_ctrl on a shrunken raster: a cycle model
// based on lock-streak length and elapsed RUN time predicts every output cycle.
module tb_hdmi_timing_ctrl;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;
    localparam int LW = 4, FPP = 2, NP = 3;

    logic       pixclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_locked = 1'b0;
    logic       pattern_hold = 1'b0;
    logic       video_en, de, hsync, vsync, frame_start;
    logic [9:0] hcount, vcount;
    logic [1:0] pattern_sel;

    hdmi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACT(1'b0), .LOCK_WAIT(LW), .FRAMES_PER_PATTERN(FPP), .NUM_PATTERNS(NP)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n), .clk_locked(clk_locked), .pattern_hold(pattern_hold),
        .video_en(video_en), .hcount(hcount), .vcount(vcount), .de(de),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .pattern_sel(pattern_sel)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        logic ven; int h; int v; logic de; logic hs; logic vs; logic fs; int pat;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: RUN holds once the synchronized lock has been high LW edges in a row.
    logic hist0, hist1, ls;
    int   streak, fcnt, pat, t, t_old;
    bit   was_run, run;

    always @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            hist0 = 1'b0; hist1 = 1'b0; streak = 0; fcnt = 0; pat = 0;
            sb_q.delete();
        end else begin
            exp_t e;
            ls      = hist1;
            hist1   = hist0;
            hist0   = clk_locked;
            was_run = (streak >= LW);
            t_old   = streak - LW;
            streak  = ls ? streak + 1 : 0;
            run     = (streak >= LW);
            t       = streak - LW;
            if (was_run && run && (t_old % FR == FR - 1) && !pattern_hold) begin
                fcnt++;
                if (fcnt == FPP) begin
                    fcnt = 0;
                    pat  = (pat + 1) % NP;
                end
            end
            if (!run) fcnt = 0;
            e.ven = run;
            e.h   = run ? t % HT : 0;
            e.v   = run ? (t / HT) % VT : 0;
            e.de  = run && (e.h < HA) && (e.v < VA);
            e.hs  = !(run && (e.h >= HA + HFP) && (e.h < HA + HFP + HS));
            e.vs  = !(run && (e.v >= VA + VFP) && (e.v < VA + VFP + VS));
            e.fs  = run && (e.h == 0) && (e.v == 0);
            e.pat = pat;
            sb_q.push_back(e);
        end
    end

    always @(negedge pixclk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (video_en !== e.ven || int'(hcount) != e.h || int'(vcount) != e.v ||
                de !== e.de || hsync !== e.hs || vsync !== e.vs ||
                frame_start !== e.fs || int'(pattern_sel) != e.pat) begin
                miscompares++;
                $display("FAIL scoreboard @%0t: got ven=%b h=%0d v=%0d de=%b hs=%b vs=%b fs=%b pat=%0d, want ven=%b h=%0d v=%0d de=%b hs=%b vs=%b fs=%b pat=%0d",
                         $time, video_en, hcount, vcount, de, hsync, vsync, frame_start, pattern_sel,
                         e.ven, e.h, e.v, e.de, e.hs, e.vs, e.fs, e.pat);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pixclk);
            #2;
        end
    endtask

    task automatic check_blank(input string tag, input int exp_pat);
        check({tag, "_video_en"}, video_en, 0);
        check({tag, "_hcount"}, hcount, 0);
        check({tag, "_vcount"}, vcount, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_pattern_sel"}, pattern_sel, exp_pat);
    endtask

    int pat_log[$];
    int fs_at[$];
    int exp_pat[7] = '{0, 0, 1, 1, 2, 2, 0};
    int n, de_n, hs_n, vs_n, prev_pat, lo_left;

    initial begin
        #23;
        check_blank("reset", 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check_blank("idle", 0);

        // Start-up latency from the first edge sampling lock high.
        clk_locked = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            check("startup_video_en", video_en, (i >= 6) ? 1 : 0);
            if (i == 6) begin
                check("startup_frame_start", frame_start, 1);
                check("startup_hcount", hcount, 0);
                check("startup_vcount", vcount, 0);
                check("startup_de", de, 1);
            end else if (i < 6) begin
                check("startup_de_blank", de, 0);
            end
        end
        clk_locked = 1'b0;
        step(10);

        // Lock glitch restarts the settle count.
        clk_locked = 1'b1; step(2);
        clk_locked = 1'b0; step(3);
        clk_locked = 1'b1;
        n = 0;
        while (!video_en && n < 50) begin
            step(1);
            n++;
        end
        check("glitch_run_latency", n, LW + 2);

        // Seven frames of raster and pattern stepping.
        de_n = 0; hs_n = 0; vs_n = 0; prev_pat = 0;
        for (int c = 0; c < 7 * FR; c++) begin
            if (c > 0) step(1);
            if (frame_start) begin
                pat_log.push_back(int'(pattern_sel));
                fs_at.push_back(c);
            end
            if (int'(pattern_sel) != prev_pat) begin
                check("pattern_change_on_frame_start", frame_start, 1);
                prev_pat = int'(pattern_sel);
            end
            if (c < FR) begin
                de_n += int'(de);
                hs_n += int'(!hsync);
                vs_n += int'(!vsync);
            end
        end
        check("frame_start_count", pat_log.size(), 7);
        for (int k = 0; k < 7 && k < pat_log.size(); k++) begin
            check("pattern_seq", pat_log[k], exp_pat[k]);
            if (k > 0) check("frame_period", fs_at[k] - fs_at[k-1], FR);
        end
        check("de_cycles", de_n, HA * VA);
        check("hsync_cycles", hs_n, HS * VT);
        check("vsync_cycles", vs_n, VS * HT);

        // Hold across two end-of-frames, then resume.
        pattern_hold = 1'b1;
        step(2 * FR);
        check("hold_frozen", pattern_sel, 0);
        pattern_hold = 1'b0;
        step(1);
        check("hold_release_first", pattern_sel, 0);
        step(FR);
        check("hold_resume_step", pattern_sel, 1);

        // Mid-frame lock loss.
        n = 0;
        while (!(hcount == 10'd10 && vcount == 10'd5) && n < 2 * FR) begin
            step(1);
            n++;
        end
        check("drop_point_reached", (n < 2 * FR) ? 1 : 0, 1);
        clk_locked = 1'b0;
        step(1); check("drop_edge1_video_en", video_en, 1);
        step(1); check("drop_edge2_video_en", video_en, 1);
        step(1); check_blank("drop", 1);
        clk_locked = 1'b1;
        n = 0;
        while (!video_en && n < 50) begin
            step(1);
            n++;
        end
        check("relock_run_latency", n, LW + 2);
        check("relock_hcount", hcount, 0);
        check("relock_vcount", vcount, 0);
        check("relock_frame_start", frame_start, 1);
        step(3 * FR);

        // Randomized lock drops and pattern holds.
        lo_left = 0;
        for (int c = 0; c < 8000; c++) begin
            if (lo_left > 0) begin
                lo_left--;
                if (lo_left == 0) clk_locked = 1'b1;
            end else if ($urandom_range(0, 1999) == 0) begin
                clk_locked = 1'b0;
                lo_left = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 299) == 0) pattern_hold = ~pattern_hold;
            step(1);
        end

        // Reset asserted mid-frame.
        pattern_hold = 1'b0;
        clk_locked = 1'b1;
        step(20);
        n = 0;
        while (!(video_en && hcount == 10'd7) && n < 2 * FR) begin
            step(1);
            n++;
        end
        check("reset_point_reached", (n < 2 * FR) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        check_blank("midreset", 0);
        #20;
        rst_n = 1'b1;
        step(LW + 2 + 2 * FR);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
